// File: rtl/sub_seq.sv
// ---------------------------------------------------------------------------
// sub_seq : multi-cycle wide unsigned subtractor.
//
// Computes (in1 - in2) mod 2^WIDTH one LIMB-bit limb per clock, least
// significant limb first, carrying the borrow from limb to limb. The operands
// are captured when a request is accepted, so the controller may change the
// inputs immediately afterwards.
//
// Parameters
//   WIDTH : operand / result width (multiple of LIMB)
//   LIMB  : limb width handled per cycle
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   start      : request, only looked at while idle
//   in1        : minuend, captured on the accepting edge
//   in2        : subtrahend, captured on the accepting edge
//   busy       : high while limbs are being processed
//   done       : one-cycle pulse, out / borrow_out are final
//   out        : (in1 - in2) mod 2^WIDTH
//   borrow_out : 1 when in1 < in2 (unsigned)
// ---------------------------------------------------------------------------
module sub_seq #(
    parameter int WIDTH = 1024,
    parameter int LIMB  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out
);

    localparam int NLIMB = WIDTH / LIMB;
    // The limb index keeps at least one bit so the single-limb build still
    // has a legal vector.
    localparam int IW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IW-1:0]       idx;
    logic                borrow;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [LIMB-1:0]     a_limb;
    logic [LIMB-1:0]     b_limb;
    logic [LIMB:0]       d;
    logic                last;

    // One limb of the subtraction; the extra top bit of the result is the
    // borrow that goes to the next limb.
    function automatic logic [LIMB:0] limb_sub(
        input logic [LIMB-1:0] a,
        input logic [LIMB-1:0] b,
        input logic            bin
    );
        logic [LIMB:0] r;
        r = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
        return r;
    endfunction

    // Select the current limb of both latched operands.
    always_comb begin
        a_limb = {LIMB{1'b0}};
        b_limb = {LIMB{1'b0}};
        for (int k = 0; k < NLIMB; k++) begin
            if (idx == IW'(k)) begin
                a_limb = a_reg[k*LIMB +: LIMB];
                b_limb = b_reg[k*LIMB +: LIMB];
            end else begin
                a_limb = a_limb;
                b_limb = b_limb;
            end
        end
    end

    // Limb difference and end-of-operand detection.
    always_comb begin
        d    = limb_sub(a_limb, b_limb, borrow);
        last = (idx == IW'(NLIMB - 1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end else begin
                    next_state = RUN;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, limb sequencing and result write-back. Limbs not yet
    // rewritten keep their value from the previous operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= {WIDTH{1'b0}};
            b_reg      <= {WIDTH{1'b0}};
            idx        <= {IW{1'b0}};
            borrow     <= 1'b0;
            out        <= {WIDTH{1'b0}};
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= in1;
                        b_reg  <= in2;
                        idx    <= {IW{1'b0}};
                        borrow <= 1'b0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NLIMB; k++) begin
                        if (idx == IW'(k)) begin
                            out[k*LIMB +: LIMB] <= d[LIMB-1:0];
                        end
                    end
                    borrow <= d[LIMB];
                    if (last) begin
                        borrow_out <= d[LIMB];
                    end else begin
                        idx <= idx + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    borrow <= borrow;
                end
                default: begin
                    borrow <= borrow;
                end
            endcase
        end
    end

endmodule

// File: doc/sub_seq.md
# sub_seq

Multi-cycle 1024-bit unsigned subtractor: computes `in1 - in2` one 256-bit limb per clock, least-significant limb first, and propagates the borrow between limbs. It is the inverse-operation companion to the team's pipelined wide adder and shares its operand widths and limb split. Together they provide both directions of big-number arithmetic for the modular-reduction datapath. A start/busy/done handshake lets a controller issue one subtraction at a time and sample a stable result.

## Interface
- `WIDTH`, default 1024: operand and result width in bits. Must be a multiple of `LIMB`.
- `LIMB`, default 256: limb width processed per cycle. `NLIMB = WIDTH/LIMB` must be at least 1.
- `clk`, input, 1: single clock. All state updates on the posedge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `in1`, input, WIDTH: minuend. Sampled at the accepting edge only.
- `in2`, input, WIDTH: subtrahend. Sampled at the accepting edge only.
- `busy`, output, 1: high while limbs are being processed (RUN).
- `done`, output, 1: single-cycle pulse meaning `out` and `borrow_out` are final.
- `out`, output, WIDTH: `(in1 - in2) mod 2^WIDTH`.
- `borrow_out`, output, 1: 1 if and only if `in1 < in2` (unsigned).

## Operation
- States: IDLE, RUN, DONE. The state register is 2 bits, with a `$clog2(NLIMB)`-bit limb index `idx` (minimum 1 bit) and a 1-bit internal `borrow`.
- IDLE:
  - When `start=1` at the posedge, latch `in1` into `a_reg` and `in2` into `b_reg`.
  - Set `idx<=0` and `borrow<=0`, then go to RUN.
  - When `start=0`, stay in IDLE.
- RUN, each posedge:
  - Compute `d = {1'b0, a_limb} - {1'b0, b_limb} - borrow`, a LIMB+1-bit result, where `a_limb = a_reg[idx*LIMB +: LIMB]` and `b_limb` is the same slice of `b_reg`.
  - Write `out[idx*LIMB +: LIMB] <= d[LIMB-1:0]` and `borrow <= d[LIMB]`.
  - If `idx == NLIMB-1`: set `borrow_out <= d[LIMB]`, go to DONE, keep `idx` unchanged. Otherwise `idx <= idx+1`.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs decode from state: `busy = (state==RUN)` and `done = (state==DONE)`.
- `start` is ignored in RUN and DONE. The earliest re-accept is the posedge that leaves IDLE, one cycle after `done`.
- Limbs of `out` that have not yet been rewritten keep their previous values. `out` is only guaranteed coherent while `done=1` and afterwards until the next accept.
- Operands are latched, so `in1` and `in2` may change freely after the accepting edge.
- Reset, asynchronous and active-high, including mid-operation:
  - State goes to IDLE; `idx`, `borrow`, `a_reg`, `b_reg` go to 0.
  - `out` goes to 0, `borrow_out` to 0, `busy` to 0, `done` to 0.
  - An in-flight operation is discarded with no `done` pulse.
  - Start is accepted at the first posedge after `rst` deasserts.

## Timing
- Accept edge E0. Limb k is written at edge E(k+1).
- `busy=1` from E0 to E(NLIMB). `done=1` from E(NLIMB) to E(NLIMB+1).
- Latency from accept edge to `done` is NLIMB cycles (4 at defaults).
- Throughput is one operation per NLIMB+2 cycles when `start` is held high.
- With NLIMB=1: RUN lasts one cycle and `done` rises at E1.
- `out` and `borrow_out` hold their values after DONE until limb 0 of the next operation is written.

## Test plan
- Simple subtraction: `in1=5`, `in2=3` with `start` pulsed → `done` exactly 4 cycles after the accept edge; `out=2`, `borrow_out=0`; `busy` high for 4 cycles.
- Borrow chain across all limbs: `in1=2^768`, `in2=1` → `out` has bits [767:0] all 1 and upper limb 0; `borrow_out=0`.
- Underflow: `in1=0`, `in2=1` → `out` = all ones (1024 bits), `borrow_out=1`. Then `in1=in2=0xDEAD…` (random equal values) → `out=0`, `borrow_out=0`.
- Handshake: hold `start=1` continuously → one `done` every 6 cycles. Change `in1`/`in2` mid-RUN → result reflects the latched operands. A `start` pulse during RUN or DONE is ignored.
- Reset mid-operation: assert `rst` asynchronously (between edges) 2 cycles after accept → all outputs are 0 immediately with no `done` pulse. A new start after release gives a correct result.
- Random regression: 10k random operand pairs compared against a `{borrow,out} = {1'b0,in1} - {1'b0,in2}` reference model; also run with `WIDTH=256`, `LIMB=256` (NLIMB=1, `done` at E1).
